// File: rtl/mdu_pkg.sv
// Shared definitions for the MIPS32 multiply/divide unit: op codes, FSM states,
// operand width and iteration counter width.
package mdu_pkg;

  localparam int MDU_N     = 32;
  localparam int MDU_CNT_W = $clog2(MDU_N) + 1;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } mdu_state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Combinational sign handling: operand magnitudes and result sign flags on entry,
// two's-complement correction of the raw unsigned product/quotient/remainder on exit.
module mdu_sign_fix
  import mdu_pkg::*;
#(
  parameter int N = MDU_N
) (
  input  logic [1:0]     op,
  input  logic [N-1:0]   in_a,
  input  logic [N-1:0]   in_b,
  output logic [N-1:0]   mag_a,
  output logic [N-1:0]   mag_b,
  output logic           neg_res_in,
  output logic           neg_rem_in,
  input  logic [2*N-1:0] raw_prod,
  input  logic [N-1:0]   raw_quot,
  input  logic [N-1:0]   raw_rem,
  input  logic           neg_res,
  input  logic           neg_rem,
  output logic [2*N-1:0] fix_prod,
  output logic [N-1:0]   fix_quot,
  output logic [N-1:0]   fix_rem
);

  logic is_signed;

  assign is_signed  = (op == MDU_MULT) || (op == MDU_DIV);
  assign mag_a      = (is_signed && in_a[N-1]) ? -in_a : in_a;
  assign mag_b      = (is_signed && in_b[N-1]) ? -in_b : in_b;
  assign neg_res_in = is_signed && (in_a[N-1] ^ in_b[N-1]);
  // The remainder follows the dividend's sign.
  assign neg_rem_in = is_signed && in_a[N-1];

  assign fix_prod = neg_res ? -raw_prod : raw_prod;
  assign fix_quot = neg_res ? -raw_quot : raw_quot;
  assign fix_rem  = neg_rem ? -raw_rem  : raw_rem;

endmodule

// File: rtl/mult_div_unit.sv
// Iterative shift-add multiplier / restoring divider producing HI/LO, with start/busy/done.
// Optional macro MDU_EARLY_OUT_EN: multiply stops once the remaining multiplier bits are zero.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int N = MDU_N
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  input  logic         mthi,
  input  logic         mtlo,
  input  logic [N-1:0] wd,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CNT_W = MDU_CNT_W;

  mdu_state_e       state_reg, state_next;
  logic [1:0]       op_reg;
  logic             neg_res_reg, neg_rem_reg, div0_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [2*N-1:0]   acc_reg, mcand_reg;
  logic [N-1:0]     opb_reg, hi_reg, lo_reg;

  logic [N-1:0]     mag_a, mag_b;
  logic             neg_res_in, neg_rem_in;
  logic [2*N-1:0]   fix_prod;
  logic [N-1:0]     fix_quot, fix_rem;

  logic             start_acc, is_div, last_iter;
  logic [2*N-1:0]   acc_mul, acc_div, acc_step;
  logic [N:0]       rem_sh;
  logic [N+1:0]     diff;
  logic [N-1:0]     hi_fin, lo_fin;

  mdu_sign_fix #(.N(N)) u_sign_fix (
    .op         (op),
    .in_a       (inA),
    .in_b       (inB),
    .mag_a      (mag_a),
    .mag_b      (mag_b),
    .neg_res_in (neg_res_in),
    .neg_rem_in (neg_rem_in),
    .raw_prod   (acc_step),
    .raw_quot   (acc_step[N-1:0]),
    .raw_rem    (acc_step[2*N-1:N]),
    .neg_res    (neg_res_reg),
    .neg_rem    (neg_rem_reg),
    .fix_prod   (fix_prod),
    .fix_quot   (fix_quot),
    .fix_rem    (fix_rem)
  );

  assign start_acc = start && (state_reg != RUN);
  assign is_div    = op_reg[1];

  // Multiply: accumulate the left-shifted multiplicand under the current multiplier bit.
  assign acc_mul = acc_reg + (opb_reg[0] ? mcand_reg : '0);

  // Divide: acc holds {remainder, dividend/quotient}; one extra guard bit keeps
  // the borrow correct even for a zero divisor.
  assign rem_sh   = acc_reg[2*N-1:N-1];
  assign diff     = {1'b0, rem_sh} - {2'b00, opb_reg};
  assign acc_div  = diff[N+1] ? {rem_sh[N-1:0], acc_reg[N-2:0], 1'b0}
                              : {diff[N-1:0],   acc_reg[N-2:0], 1'b1};
  assign acc_step = is_div ? acc_div : acc_mul;

`ifdef MDU_EARLY_OUT_EN
  assign last_iter = is_div ? (cnt_reg == CNT_W'(N-1)) : (opb_reg[N-1:1] == '0);
`else
  assign last_iter = (cnt_reg == CNT_W'(N-1));
`endif

  assign hi_fin = is_div ? fix_rem : fix_prod[2*N-1:N];
  assign lo_fin = is_div ? (div0_reg ? '1 : fix_quot) : fix_prod[N-1:0];

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (last_iter) state_next = DONE;
      DONE:    state_next = start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg   <= IDLE;
      op_reg      <= 2'b00;
      neg_res_reg <= 1'b0;
      neg_rem_reg <= 1'b0;
      div0_reg    <= 1'b0;
      cnt_reg     <= '0;
      acc_reg     <= '0;
      mcand_reg   <= '0;
      opb_reg     <= '0;
      hi_reg      <= '0;
      lo_reg      <= '0;
    end else begin
      state_reg <= state_next;
      if (start_acc) begin
        op_reg      <= op;
        neg_res_reg <= neg_res_in;
        neg_rem_reg <= neg_rem_in;
        div0_reg    <= (inB == '0);
        cnt_reg     <= '0;
        acc_reg     <= op[1] ? {{N{1'b0}}, mag_a} : '0;
        mcand_reg   <= {{N{1'b0}}, mag_a};
        opb_reg     <= mag_b;
      end else if (state_reg == RUN) begin
        cnt_reg <= cnt_reg + CNT_W'(1);
        acc_reg <= acc_step;
        if (!is_div) begin
          mcand_reg <= mcand_reg << 1;
          opb_reg   <= opb_reg >> 1;
        end
        if (last_iter) begin
          hi_reg <= hi_fin;
          lo_reg <= lo_fin;
        end
      end else begin
        if (mthi) hi_reg <= wd;
        if (mtlo) lo_reg <= wd;
      end
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: signed/unsigned multiply and divide, divide
// corner cases, MTHI/MTLO, start-while-busy and mid-operation reset.
module tb_mult_div_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] inA, inB, wd;
  logic        mthi, mtlo;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks   = 0;
  int failures = 0;

`ifdef MDU_EARLY_OUT_EN
  localparam int EO_LAT = 3;
`else
  localparam int EO_LAT = 33;
`endif

  mult_div_unit dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .op    (op),
    .inA   (inA),
    .inB   (inB),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wd    (wd),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  // Issue one op, then watch it to completion: busy/hold in the first cycle,
  // latency in cycles after the start edge, result, and single-cycle done.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic [31:0] old_hi, input logic with_mthi);
    int  cyc;
    bit  got;
    @(negedge clock);
    start = 1'b1; op = o; inA = a; inB = b;
    mthi = with_mthi; wd = 32'hDEAD_BEEF;
    @(posedge clock);
    #1;
    start = 1'b0; mthi = 1'b0;
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 100) begin
      @(negedge clock);
      cyc++;
      if (cyc == 1) begin
        check({tag, "_busy"}, 32'(busy), 32'd1);
        check({tag, "_hold_hi"}, hi, old_hi);
      end
      if (done) got = 1'b1;
    end
    check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
    @(negedge clock);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; op = 2'b00;
    inA = '0; inB = '0; wd = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b1;

    run_op("mult_neg",  2'b00, 32'hFFFF_FFFD, 32'd5,        33, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'h0,         1'b0);
    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0);
    run_op("div_neg",   2'b10, 32'hFFFF_FFF9, 32'd2,        33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 1'b0);
    run_op("divu_by0",  2'b11, 32'd100,       32'd0,        33, 32'h0000_0064, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("div_ovf",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0,        32'h8000_0000, 32'h0000_0064, 1'b0);

    // Moves while idle.
    @(negedge clock);
    mthi = 1'b1; wd = 32'h0000_1234;
    @(negedge clock);
    mthi = 1'b0; mtlo = 1'b1; wd = 32'h0000_5678;
    check("mthi_idle", hi, 32'h0000_1234);
    @(negedge clock);
    mtlo = 1'b0;
    check("mtlo_idle", lo, 32'h0000_5678);

    // start and mthi together: start wins, hi keeps 0x1234 until done.
    run_op("startwins", 2'b01, 32'd7, 32'd3, EO_LAT, 32'h0, 32'd21, 32'h0000_1234, 1'b1);

    @(negedge clock);
    mthi = 1'b1; wd = 32'h0000_AAAA;
    @(negedge clock);
    mthi = 1'b0;
    check("mthi_seed", hi, 32'h0000_AAAA);

    // Busy scenario: restart at k+5 and mthi at k+6 are ignored; reset at k+40.
    begin
      int  cyc;
      int  done_cyc;
      done_cyc = 0;
      start = 1'b1; op = 2'b01; inA = 32'd7; inB = 32'h8000_0001;
      @(posedge clock);
      #1;
      start = 1'b0;
      for (cyc = 1; cyc <= 41; cyc++) begin
        @(negedge clock);
        if (done && done_cyc == 0) done_cyc = cyc;
        case (cyc)
          4:  begin start = 1'b1; op = 2'b11; inA = 32'd9; inB = 32'd3; end
          5:  begin start = 1'b0; mthi = 1'b1; wd = 32'h0000_BBBB; end
          6:  mthi = 1'b0;
          7:  check("busy_mid", 32'(busy), 32'd1);
          10: check("busy_hold_hi", hi, 32'h0000_AAAA);
          33: begin
                check("busy_hi", hi, 32'h0000_0003);
                check("busy_lo", lo, 32'h8000_0007);
              end
          36: begin start = 1'b1; op = 2'b11; inA = 32'd1000; inB = 32'd7; end
          37: start = 1'b0;
          39: begin check("op2_busy", 32'(busy), 32'd1); reset = 1'b0; end
          40: begin
                check("midrst_busy", 32'(busy), 32'd0);
                check("midrst_done", 32'(done), 32'd0);
                check("midrst_hi", hi, 32'd0);
                check("midrst_lo", lo, 32'd0);
                reset = 1'b1;
              end
          default: ;
        endcase
      end
      check("busy_latency", 32'(done_cyc), 32'd33);
      repeat (3) @(negedge clock);
      check("after_rst_idle", 32'(busy), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multi-cycle MIPS32 multiply/divide unit in the EX stage, beside the single-cycle ALU.
- Consumes the register-file read operands rdA/rdB.
- Produces the architectural HI/LO registers, which the write-back path reads for MFHI/MFLO.
- Uses an iterative shift-add multiplier and a restoring divider, with a start/busy/done handshake to the pipeline control.

Parameters:
N, 32, operand width; HI and LO are each N bits; the iteration count equals N.

Ports:
clock  input  1  system clock; all state changes on posedge
reset  input  1  synchronous, active-low reset; sampled on posedge clock
start  input  1  request; accepted only when busy=0
op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
inA  input  N  rs operand (multiplicand / dividend)
inB  input  N  rt operand (multiplier / divisor)
mthi  input  1  MTHI: load HI from wd
mtlo  input  1  MTLO: load LO from wd
wd  input  N  data for MTHI/MTLO
busy  output  1  operation in progress
done  output  1  one-cycle pulse; HI/LO are valid in the same cycle
hi  output  N  HI register (product high / remainder)
lo  output  N  LO register (product low / quotient)

Behaviour:
- Reset (reset=0 at posedge):
  - state=IDLE; hi=0, lo=0, busy=0, done=0.
  - Any operation in progress is aborted and its result discarded.
- States:
  - IDLE -> RUN when start=1. Latch op, |inA|, |inB| and the result sign flags (signed ops only); load iteration counter=0.
  - RUN: one iteration per cycle.
    - Multiply: add the shifted multiplicand if the multiplier bit is set, then shift. The 2N-bit accumulator is internal.
    - Divide: one restoring subtract/shift step.
    - After N iterations -> DONE. HI/LO are written on that edge with the sign-corrected result.
  - DONE: done=1 for exactly one cycle. -> RUN if start=1 (back-to-back), else -> IDLE.
- Latency: start sampled at posedge k -> busy=1 during cycles k+1..k+N -> done=1 and new hi/lo visible in cycle k+N+1.
- start while busy=1 is ignored; the in-flight operation is unaffected.
- hi/lo hold their value during RUN; old values remain readable until done.
- Signed ops: the operation runs on magnitudes.
  - Product is negated if the operand signs differ.
  - Quotient is negated if the signs differ; the remainder takes the dividend's sign.
- Divide by zero (DIV or DIVU, inB=0): the full N cycles still elapse; lo=all ones, hi=inA (as latched).
- Signed overflow (DIV, inA=0x80000000, inB=0xFFFFFFFF): lo=0x80000000, hi=0.
- MTHI/MTLO:
  - Honoured only when busy=0; the register updates at the next posedge.
  - Ignored while busy=1.
  - If start and mthi/mtlo are asserted in the same cycle, start wins and the move is ignored.
- All arithmetic is unsigned N/2N-bit internally; the sign is applied only at completion.

Optional Feature:
MDU_EARLY_OUT_EN
- Defined: multiply exits RUN after the iteration that leaves the remaining multiplier bits all zero (minimum 1 iteration). Latency becomes 1 + index of the highest set bit of |inB|, plus 1 for done. Divide is unchanged at N iterations.
- Undefined: fixed N iterations for all ops.

Decomposition:
- Shared package mdu_pkg:
  - op encodings MDU_MULT/MULTU/DIV/DIVU.
  - state encoding IDLE/RUN/DONE.
  - localparam for counter width $clog2(N)+1.
- One natural sub-module: mdu_sign_fix. It is combinational: magnitude extraction on entry and negation/sign correction on exit. The FSM and datapath stay in mult_div_unit.

Test Plan:
- Multiplies:
  - MULT inA=0xFFFFFFFD (-3), inB=5 -> done at k+33; hi=0xFFFFFFFF, lo=0xFFFFFFF1.
  - MULTU inA=inB=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV inA=0xFFFFFFF9 (-7), inB=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide corner cases:
  - DIVU inA=100, inB=0 -> lo=0xFFFFFFFF, hi=0x64.
  - DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- start re-asserted at k+5 with other operands, plus mthi=1 at k+6 -> ignored; the original result appears at k+33. Then reset=0 at k+40 mid-way through a second op -> busy=0, done=0, hi=lo=0 next cycle.
- With MDU_EARLY_OUT_EN: MULTU 7*3 -> done at k+3, lo=21. Without it: done at k+33, lo=21.
